// File: rtl/gray2bin_b10_reg_if.sv
// gray2bin_b10_reg_if: in_valid/gray_code toward the converter, out_valid/binary_code back
interface gray2bin_b10_reg_if #(parameter int WIDTH = 10);
  logic             in_valid;
  logic [WIDTH-1:0] gray_code;
  logic             out_valid;
  logic [WIDTH-1:0] binary_code;
  modport master (output in_valid, output gray_code, input out_valid, input binary_code);
  modport slave (input in_valid, input gray_code, output out_valid, output binary_code);
endinterface

// File: rtl/gray2bin_b10_reg.sv
// gray2bin_b10_reg: registered Gray-to-binary converter; clk, rst (sync, active-high), bus = in_valid/gray_code in, out_valid/binary_code out
module gray2bin_b10_reg #(
  parameter int WIDTH = 10
) (
  input logic clk,
  input logic rst,
  gray2bin_b10_reg_if.slave bus
);
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("gray2bin_b10_reg: WIDTH must be in 2..32");
  end
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_d, bin_q;
  logic             valid_d, valid_q;
  // Each bit is the XOR of all Gray bits from the MSB down to itself
  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
    assign bin[i] = ^bus.gray_code[WIDTH-1:i];
  end
  always_comb begin
    valid_d = bus.in_valid;
    bin_d   = bus.in_valid ? bin : bin_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
    end
  end
  assign bus.out_valid   = valid_q;
  assign bus.binary_code = bin_q;
  a_valid_delay: assert property (@(posedge clk) disable iff (rst)
    bus.out_valid == ($past(bus.in_valid) && !$past(rst)));
endmodule

// File: tb/tb_gray2bin_b10_reg.sv
// tb_gray2bin_b10_reg: scoreboard bench for the registered Gray-to-binary converter
module tb_gray2bin_b10_reg;
  localparam int W = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  logic started = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] gray_q[$];
  logic [W-1:0] hold_exp = '0;
  int checks = 0;
  int fails = 0;
  gray2bin_b10_reg_if #(.WIDTH(W)) bus ();
  gray2bin_b10_reg #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rst_seen <= rst;
    started  <= 1'b1;
  end
  function automatic logic [W-1:0] ref_conv(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check("reset_valid", W'(bus.out_valid), '0);
        check("reset_data", bus.binary_code, '0);
        hold_exp = '0;
      end else if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got out_valid=1 data %b expected no output", bus.binary_code);
        end else begin
          logic [W-1:0] e, g;
          e = exp_q.pop_front();
          g = gray_q.pop_front();
          check("result", bus.binary_code, e);
          check("reencode", bus.binary_code ^ (bus.binary_code >> 1), g);
          hold_exp = e;
        end
      end else begin
        check("idle_valid", W'(bus.out_valid), '0);
        check("hold_data", bus.binary_code, hold_exp);
      end
    end
  end
  task automatic drive(input logic r, input logic v, input logic [W-1:0] g, input logic [W-1:0] e);
    rst = r;
    bus.in_valid = v;
    bus.gray_code = g;
    if (!r && v) begin
      exp_q.push_back(e);
      gray_q.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask
  logic [W-1:0] sweep_exp [13] = '{10'd0, 10'd1, 10'd3, 10'd2, 10'd7, 10'd6, 10'd4, 10'd5,
                                   10'd15, 10'd14, 10'd12, 10'd13, 10'd8};
  initial begin
    bus.in_valid = 1'b1;
    bus.gray_code = 10'h3FF;
    drive(1'b1, 1'b1, 10'h3FF, '0);
    drive(1'b1, 1'b1, 10'h3FF, '0);
    drive(1'b0, 1'b0, 10'h3FF, '0);
    for (int i = 0; i < 13; i++) drive(1'b0, 1'b1, W'(i), sweep_exp[i]);
    drive(1'b0, 1'b1, 10'b1000000000, 10'b1111111111);
    drive(1'b0, 1'b1, 10'b1111111111, 10'b1010101010);
    drive(1'b0, 1'b1, 10'b0000000001, 10'b0000000001);
    drive(1'b0, 1'b0, 10'd0, '0);
    drive(1'b0, 1'b1, 10'd6, 10'd4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 10'd9, '0);
    drive(1'b0, 1'b1, 10'd4, 10'd7);
    drive(1'b1, 1'b1, 10'd5, 10'd6);
    drive(1'b0, 1'b1, 10'd6, 10'd4);
    drive(1'b0, 1'b0, 10'd0, '0);
    for (int i = 0; i < 1024; i++) drive(1'b0, 1'b1, W'(i), ref_conv(W'(i)));
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 1'b0, 10'd0, '0);
    drive(1'b0, 1'b0, 10'd0, '0);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/gray2bin_b10_reg.md
Name: gray2bin_b10_reg

Overview:
- Clocked 10-bit Gray-code to natural-binary converter (default width).
- Sits on datapath boundaries where Gray-coded counters or encoder positions are consumed as binary, e.g. FIFO pointer sync or rotary/absolute encoders.
- Conversion is a full XOR prefix from the MSB down.
- Result is registered with a one-cycle valid qualifier.

Parameters:
- WIDTH, 10, bit width of the Gray input and binary output; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies gray_code for capture this cycle.
- gray_code  input  WIDTH  Gray-coded input word.
- out_valid  output  1  high for exactly one cycle per accepted input, one cycle after capture.
- binary_code  output  WIDTH  converted binary word; holds its last value when out_valid is low.

Behaviour:
- Conversion function, combinational from gray_code:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0
  - Equivalently, b[i] = XOR of g[WIDTH-1:i].
- Registering: on a rising clk edge with rst=0 and in_valid=1, binary_code <= convert(gray_code) and out_valid <= 1.
- On a rising clk edge with rst=0 and in_valid=0:
  - out_valid <= 0.
  - binary_code holds its previous value and does not re-track gray_code.
- Latency: exactly 1 clk from the accepting edge to the result on binary_code with out_valid=1.
- Throughput: 1 word per cycle. Back-to-back in_valid produces back-to-back out_valid with each result in order.
- No backpressure and no ready signal; every valid input is accepted.
- Reset: on a rising edge with rst=1, binary_code <= 0 and out_valid <= 0. Reset overrides a simultaneous in_valid, so that input is dropped.
- Reset mid-stream: results in flight are discarded. The first valid input after rst deasserts is converted normally with 1-cycle latency.
- Width rules:
  - No truncation or extension; output width equals input width.
  - All-ones Gray input maps to binary 1010...(MSB=1, alternating), e.g. WIDTH=10 gives 10'b1010101010.
  - Gray 1 followed by zeros (10'b1000000000) maps to all-ones (10'b1111111111).
- No X propagation in the output register after reset, regardless of gray_code value while in_valid=0.
- Implementation structure (reference-quality RTL):
  - Generate-based XOR prefix chain.
  - Separate combinational and sequential blocks.
  - Parameter legality check at elaboration.
  - Optional assertion that out_valid is the in_valid delayed by one cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, gray_code=10'h3FF -> binary_code=0 and out_valid=0 throughout, and on the first edge after release.
- Sequential sweep: drive gray 0..12 with in_valid=1 each cycle -> next-cycle binary sequence 0,1,3,2,7,6,4,5,15,14,12,13,8 with out_valid=1 on each.
- Boundaries: gray 10'b1000000000 -> 10'b1111111111; gray 10'b1111111111 -> 10'b1010101010; gray 10'b0000000001 -> 10'b0000000001.
- Hold: accept gray 6 (binary 4), then in_valid=0 while gray_code changes to 9 for 3 cycles -> out_valid=0 and binary_code stays 4.
- Reset mid-stream: stream gray 4,5,6 and assert rst on the cycle gray 5 is presented -> gray 5 dropped, out_valid=0 and binary_code=0 after the reset edge; gray 6 after release yields binary 4.
- Exhaustive: all 1024 Gray codes back-to-back -> each output equals reference XOR-prefix, and re-encoding the output (b XOR b>>1) equals the input.
